// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared constants and helpers for the BCD digit source and its neighbours.
//   DIGIT_W            width of one decimal digit (also used by the decoder)
//   DEFAULT_MAX_DIGIT  highest digit before wrap for a plain decimal counter
//   DEFAULT_TICK_DIV   clk cycles per step tick (1 Hz at a 12 MHz board clock)
//   DECODER_IN_W       width of the seven-segment decoder's numeric input
//   step_digit()       one up/down step with wrap, returns {wrap, next_digit}
//   to_decoder_in()    zero-extends a digit onto the decoder input
// -----------------------------------------------------------------------------
package bcd_pkg;

  localparam int unsigned DIGIT_W           = 4;
  localparam int unsigned DEFAULT_MAX_DIGIT = 9;
  localparam int unsigned DEFAULT_TICK_DIV  = 12000000;
  localparam int unsigned DECODER_IN_W      = 7;

  // One counting step. The wrap flag is returned in the MSB so the caller can
  // unpack carry and digit with a single concatenation.
  function automatic logic [DIGIT_W:0] step_digit(
    input logic [DIGIT_W-1:0] cur,
    input logic               up,
    input logic [DIGIT_W-1:0] max_d
  );
    logic [DIGIT_W:0] res;
    if (up) begin
      if (cur == max_d) res = {1'b1, {DIGIT_W{1'b0}}};
      else              res = {1'b0, cur + DIGIT_W'(1)};
    end else begin
      if (cur == '0)    res = {1'b1, max_d};
      else              res = {1'b0, cur - DIGIT_W'(1)};
    end
    return res;
  endfunction

  // The decoder takes a wider numeric input; digits are simply zero-extended.
  function automatic logic [DECODER_IN_W-1:0] to_decoder_in(
    input logic [DIGIT_W-1:0] d
  );
    return {{(DECODER_IN_W - DIGIT_W){1'b0}}, d};
  endfunction

endpackage

// File: rtl/bcd_tick_counter_tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// Prescaler that divides clk by TICK_DIV while enabled.
//   clk   system clock
//   rst   asynchronous active-high reset, clears the prescaler
//   en    count enable; when low the prescaler holds its value
//   clr   synchronous clear back to 0, wins over counting
//   term  combinational: enabled and sitting on the last count (TICK_DIV-1)
// -----------------------------------------------------------------------------
module tick_gen
  import bcd_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic term
);

  // A divide-by-1 still needs one bit of storage so the ports stay legal;
  // that bit simply never leaves 0.
  localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] TERM_VAL = PRESC_W'(TICK_DIV - 1);

  logic [PRESC_W-1:0] presc_reg;
  logic [PRESC_W-1:0] presc_next;

  assign term = en && (presc_reg == TERM_VAL);

  always_comb begin
    presc_next = presc_reg;
    if (clr) begin
      presc_next = '0;
    end else if (term) begin
      presc_next = '0;
    end else if (en) begin
      presc_next = presc_reg + PRESC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_reg <= '0;
    end else begin
      presc_reg <= presc_next;
    end
  end

endmodule

// File: rtl/bcd_tick_counter.sv
// -----------------------------------------------------------------------------
// bcd_tick_counter
// Free-running single BCD digit that steps up or down once per prescaler tick.
//   clk        system clock
//   rst        asynchronous active-high reset
//   en         count enable; low freezes prescaler and digit
//   up_dn      1 = count up, 0 = count down
//   load       one-cycle request to load load_val (independent of en)
//   load_val   value to load; values above MAX_DIGIT are ignored
//   digit      current digit, registered, always 0..MAX_DIGIT
//   tick       one-cycle pulse on each step
//   carry      one-cycle pulse when a step wraps, for cascading digits
//   digit_upd  one-cycle pulse whenever digit was written (step or load)
// -----------------------------------------------------------------------------
module bcd_tick_counter
  import bcd_pkg::*;
#(
  parameter int unsigned TICK_DIV  = DEFAULT_TICK_DIV,
  parameter int unsigned MAX_DIGIT = DEFAULT_MAX_DIGIT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               up_dn,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_val,
  output logic [DIGIT_W-1:0] digit,
  output logic               tick,
  output logic               carry,
  output logic               digit_upd
);

  localparam logic [DIGIT_W-1:0] MAX_D = DIGIT_W'(MAX_DIGIT);

  logic               load_ok;
  logic               load_bad;
  logic               term;
  logic               step;

  logic [DIGIT_W-1:0] digit_reg;
  logic [DIGIT_W-1:0] digit_next;
  logic               tick_reg;
  logic               tick_next;
  logic               carry_reg;
  logic               carry_next;
  logic               upd_reg;
  logic               upd_next;

  // An out-of-range load is dropped completely: it must not touch the digit,
  // and it also freezes the prescaler for that cycle so a coincident step is
  // deferred rather than lost or taken.
  assign load_ok  = load && (load_val <= MAX_D);
  assign load_bad = load && !load_ok;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (en && !load_bad),
    .clr  (load_ok),
    .term (term)
  );

  // Any load request, valid or not, blocks the step on that edge.
  assign step = term && !load;

  always_comb begin
    digit_next = digit_reg;
    tick_next  = 1'b0;
    carry_next = 1'b0;
    upd_next   = 1'b0;
    if (load_ok) begin
      digit_next = load_val;
      upd_next   = 1'b1;
    end else if (step) begin
      {carry_next, digit_next} = step_digit(digit_reg, up_dn, MAX_D);
      tick_next = 1'b1;
      upd_next  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_reg <= '0;
      tick_reg  <= 1'b0;
      carry_reg <= 1'b0;
      upd_reg   <= 1'b0;
    end else begin
      digit_reg <= digit_next;
      tick_reg  <= tick_next;
      carry_reg <= carry_next;
      upd_reg   <= upd_next;
    end
  end

  assign digit     = digit_reg;
  assign tick      = tick_reg;
  assign carry     = carry_reg;
  assign digit_upd = upd_reg;

endmodule

// File: tb/tb_bcd_tick_counter.sv
// -----------------------------------------------------------------------------
// tb_bcd_tick_counter
// Three instances share one set of inputs:
//   0: TICK_DIV=4, MAX_DIGIT=9   1: TICK_DIV=4, MAX_DIGIT=5   2: TICK_DIV=1, MAX_DIGIT=9
// A table of vectors checks instance 0, hand sequences cover asynchronous
// reset, the MAX_DIGIT=5 down wrap and TICK_DIV=1, and a random phase checks
// all instances against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_bcd_tick_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up_dn;
  logic       load;
  logic [3:0] load_val;

  logic [3:0] dg  [3];
  logic       tk  [3];
  logic       cy  [3];
  logic       upd [3];

  localparam int TDV [3] = '{4, 4, 1};
  localparam int MXV [3] = '{9, 5, 9};

  int n_cmp = 0;
  int n_bad = 0;

  bcd_tick_counter #(.TICK_DIV(4), .MAX_DIGIT(9)) dut_a (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .digit(dg[0]), .tick(tk[0]), .carry(cy[0]), .digit_upd(upd[0]));
  bcd_tick_counter #(.TICK_DIV(4), .MAX_DIGIT(5)) dut_b (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .digit(dg[1]), .tick(tk[1]), .carry(cy[1]), .digit_upd(upd[1]));
  bcd_tick_counter #(.TICK_DIV(1), .MAX_DIGIT(9)) dut_c (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .digit(dg[2]), .tick(tk[2]), .carry(cy[2]), .digit_upd(upd[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    int digit;
    int phase;   // enabled cycles elapsed since the last tick/load/reset
    int tick;
    int carry;
    int upd;
  } mstate_t;

  mstate_t m [3];

  function automatic mstate_t model_step(input mstate_t s, input int td, input int mx,
                                         input logic e, input logic up, input logic ld,
                                         input int lv);
    mstate_t n;
    n       = s;
    n.tick  = 0;
    n.carry = 0;
    n.upd   = 0;
    if (ld) begin
      if (lv <= mx) begin
        n.digit = lv;
        n.phase = 0;
        n.upd   = 1;
      end
    end else if (e) begin
      n.phase = s.phase + 1;
      if (n.phase == td) begin
        n.phase = 0;
        n.tick  = 1;
        n.upd   = 1;
        if (up) begin
          n.carry = (s.digit == mx) ? 1 : 0;
          n.digit = (s.digit + 1) % (mx + 1);
        end else begin
          n.carry = (s.digit == 0) ? 1 : 0;
          n.digit = (s.digit + mx) % (mx + 1);
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) m[k] <= '{0, 0, 0, 0, 0};
      else     m[k] <= model_step(m[k], TDV[k], MXV[k], en, up_dn, load, int'(load_val));
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int k, input int d, input int t,
                           input int c, input int u);
    check($sformatf("%s[%0d].digit", tag, k), int'(dg[k]), d);
    check($sformatf("%s[%0d].tick", tag, k), int'(tk[k]), t);
    check($sformatf("%s[%0d].carry", tag, k), int'(cy[k]), c);
    check($sformatf("%s[%0d].digit_upd", tag, k), int'(upd[k]), u);
  endtask

  task automatic drive(input logic r, input logic e, input logic u, input logic l,
                       input logic [3:0] v);
    rst = r; en = e; up_dn = u; load = l; load_val = v;
  endtask

  // one edge: inputs were set at the previous negedge, sample at the next one
  task automatic step_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
    step_cycle();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
  endtask

  // ---------------- vector table (instance 0) ----------------
  typedef struct {
    logic       r;
    logic       e;
    logic       u;
    logic       l;
    logic [3:0] v;
    int         d;
    int         t;
    int         c;
    int         up;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic e, input logic u, input logic l,
                     input logic [3:0] v, input int d, input int t, input int c,
                     input int up);
    vec_t x;
    x = '{r, e, u, l, v, d, t, c, up};
    vq.push_back(x);
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
    @(negedge clk);

    // reset then count up: digit k/4, tick every 4th cycle
    add(1, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 16; k++)
      add(0, 1, 1, 0, 0, k / 4, (k % 4 == 0), 0, (k % 4 == 0));
    // up wrap: load 8 (en low), then 9, then 0 with carry
    add(0, 0, 1, 1, 8, 8, 0, 0, 1);
    for (int k = 1; k <= 8; k++)
      add(0, 1, 1, 0, 0, (k < 4) ? 8 : (k < 8) ? 9 : 0, (k % 4 == 0), (k == 8), (k % 4 == 0));
    // down wrap: load 1, then 0, then 9 with carry
    add(0, 1, 0, 1, 1, 1, 0, 0, 1);
    for (int k = 1; k <= 8; k++)
      add(0, 1, 0, 0, 0, (k < 4) ? 1 : (k < 8) ? 0 : 9, (k % 4 == 0), (k == 8), (k % 4 == 0));
    // hold at presc=2 for 10 cycles, tick 2 cycles after re-enable
    add(0, 1, 0, 0, 0, 9, 0, 0, 0);
    add(0, 1, 0, 0, 0, 9, 0, 0, 0);
    for (int k = 0; k < 10; k++) add(0, 0, 0, 0, 0, 9, 0, 0, 0);
    add(0, 1, 0, 0, 0, 9, 0, 0, 0);
    add(0, 1, 0, 0, 0, 8, 1, 0, 1);
    // valid load on the term cycle wins, prescaler restarts
    for (int k = 0; k < 3; k++) add(0, 1, 0, 0, 0, 8, 0, 0, 0);
    add(0, 1, 0, 1, 7, 7, 0, 0, 1);
    for (int k = 0; k < 3; k++) add(0, 1, 0, 0, 0, 7, 0, 0, 0);
    add(0, 1, 0, 0, 0, 6, 1, 0, 1);
    // invalid load on the term cycle: nothing happens, step taken next cycle
    for (int k = 0; k < 3; k++) add(0, 1, 0, 0, 0, 6, 0, 0, 0);
    add(0, 1, 0, 1, 12, 6, 0, 0, 0);
    add(0, 1, 0, 0, 0, 5, 1, 0, 1);
    // boundary load values
    add(0, 0, 0, 1, 10, 5, 0, 0, 0);
    add(0, 0, 0, 1, 9, 9, 0, 0, 1);

    foreach (vq[i]) begin
      drive(vq[i].r, vq[i].e, vq[i].u, vq[i].l, vq[i].v);
      step_cycle();
      $display("vec %0d: rst=%0b en=%0b up=%0b load=%0b val=%0d -> digit=%0d tick=%0b carry=%0b upd=%0b",
               i, vq[i].r, vq[i].e, vq[i].u, vq[i].l, vq[i].v, dg[0], tk[0], cy[0], upd[0]);
      check_all($sformatf("vec%0d", i), 0, vq[i].d, vq[i].t, vq[i].c, vq[i].up);
    end

    // asynchronous reset mid-count: digit clears before any clock edge
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    step_cycle();
    step_cycle();
    #2 rst = 1'b1;
    #1;
    $display("async rst: digit=%0d/%0d/%0d", dg[0], dg[1], dg[2]);
    for (int k = 0; k < 3; k++) check_all("async_rst", k, 0, 0, 0, 0);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    for (int k = 1; k <= 4; k++) begin
      step_cycle();
      $display("post-rst %0d: digit=%0d tick=%0b", k, dg[0], tk[0]);
      check_all($sformatf("post_rst%0d", k), 0, (k == 4), (k == 4), 0, (k == 4));
    end

    // MAX_DIGIT=5 down wrap on instance 1
    pulse_reset();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 4'd1);
    step_cycle();
    check_all("b_load", 1, 1, 0, 0, 1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    for (int k = 1; k <= 8; k++) begin
      step_cycle();
      $display("b_down %0d: digit=%0d carry=%0b", k, dg[1], cy[1]);
      check_all($sformatf("b_down%0d", k), 1, (k < 4) ? 1 : (k < 8) ? 0 : 5,
                (k % 4 == 0), (k == 8), (k % 4 == 0));
    end

    // TICK_DIV=1 on instance 2: a step every enabled cycle
    pulse_reset();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    for (int k = 1; k <= 25; k++) begin
      step_cycle();
      $display("c_fast %0d: digit=%0d tick=%0b carry=%0b", k, dg[2], tk[2], cy[2]);
      check_all($sformatf("c_fast%0d", k), 2, k % 10, 1, (k % 10 == 0), 1);
    end

    // random phase against the reference model
    pulse_reset();
    for (int n = 0; n < 1500; n++) begin
      drive(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 15) == 0) ? ~up_dn : up_dn,
            ($urandom_range(0, 19) == 0),
            4'($urandom_range(0, 15)));
      step_cycle();
      $display("rnd %0d: rst=%0b en=%0b up=%0b load=%0b val=%0d -> %0d/%0d/%0d",
               n, rst, en, up_dn, load, load_val, dg[0], dg[1], dg[2]);
      for (int k = 0; k < 3; k++)
        check_all($sformatf("rnd%0d", n), k, m[k].digit, m[k].tick, m[k].carry, m[k].upd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
